// File: rtl/relu_grad_gate.sv
// relu_grad_gate: gates backward gradients with ReLU masks captured from the forward pass.
// Define LEAKY_GRAD_EN to pass masked-off gradients scaled by 2^-LEAK_SHIFT instead of zeroing them.
module relu_grad_gate #(
    parameter int SUM_WIDTH  = 32,
    parameter int DEPTH      = 128,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fwd_valid,
    input  logic [SUM_WIDTH-1:0]         fwd_data,
    input  logic                         bwd_valid,
    input  logic [SUM_WIDTH-1:0]         bwd_grad,
    input  logic                         clr_flags,
    output logic                         grad_valid,
    output logic [SUM_WIDTH-1:0]         grad_out,
    output logic [$clog2(DEPTH+1)-1:0]   mask_count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
`ifdef LEAKY_GRAD_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif
    logic [DEPTH-1:0]            mask_mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        push_ok, pop_ok, ovf_evt, unf_evt, popped;
    logic signed [SUM_WIDTH-1:0] leak_grad;
    logic [SUM_WIDTH-1:0]        gated;
    assign full      = mask_count == CW'(DEPTH);
    assign empty     = mask_count == '0;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop_ok    = bwd_valid && !empty;
    assign push_ok   = fwd_valid && (!full || bwd_valid);
    assign ovf_evt   = fwd_valid && full && !bwd_valid;
    assign unf_evt   = bwd_valid && empty;
    assign popped    = mask_mem[rd_ptr];
    assign leak_grad = $signed(bwd_grad) >>> LEAK_SHIFT;
    assign gated     = !pop_ok ? '0 : popped ? bwd_grad : LEAKY ? $unsigned(leak_grad) : '0;
    always_ff @(posedge clk) begin
        if (push_ok)
            mask_mem[wr_ptr] <= $signed(fwd_data) > 0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
            grad_valid <= 1'b0;
            grad_out   <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
            mask_count <= (push_ok && !pop_ok) ? mask_count + 1'b1 :
                          (pop_ok && !push_ok) ? mask_count - 1'b1 : mask_count;
            grad_valid <= bwd_valid;
            grad_out   <= bwd_valid ? gated : '0;
            overflow   <= ovf_evt || (overflow && !clr_flags);
            underflow  <= unf_evt || (underflow && !clr_flags);
        end
    end
endmodule

// File: tb/tb_relu_grad_gate.sv
// tb_relu_grad_gate: randomized bench comparing relu_grad_gate against a queue-based mask model.
// Honours LEAKY_GRAD_EN for the leaky expectations and the extra directed cases.
module tb_relu_grad_gate;
    localparam int W  = 32;
    localparam int D  = 128;
    localparam int LS = 3;
    localparam int CW = $clog2(D+1);
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          fwd_valid = 1'b0, bwd_valid = 1'b0, clr_flags = 1'b0;
    logic [W-1:0]  fwd_data = '0, bwd_grad = '0;
    logic          grad_valid, full, empty, overflow, underflow;
    logic [W-1:0]  grad_out;
    logic [CW-1:0] mask_count;
    int            n_chk = 0, n_pass = 0;
    bit            mq[$];
    bit            m_ovf, m_unf, m_gv;
    logic [W-1:0]  m_go;

    relu_grad_gate #(.SUM_WIDTH(W), .DEPTH(D), .LEAK_SHIFT(LS)) dut (
        .clk(clk), .rst_n(rst_n),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .bwd_valid(bwd_valid), .bwd_grad(bwd_grad),
        .clr_flags(clr_flags),
        .grad_valid(grad_valid), .grad_out(grad_out),
        .mask_count(mask_count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all();
        check("grad_valid", W'(grad_valid), W'(m_gv));
        check("grad_out",   grad_out, m_go);
        check("mask_count", W'(mask_count), W'(mq.size()));
        check("full",       W'(full), W'(mq.size() == D));
        check("empty",      W'(empty), W'(mq.size() == 0));
        check("overflow",   W'(overflow), W'(m_ovf));
        check("underflow",  W'(underflow), W'(m_unf));
    endtask

    function automatic logic [W-1:0] masked_grad(input logic [W-1:0] g);
`ifdef LEAKY_GRAD_EN
        return W'($signed(g) >>> LS);
`else
        return '0;
`endif
    endfunction

    task automatic cycle(input bit fv, input logic [W-1:0] fd, input bit bv,
                         input logic [W-1:0] bg, input bit clr);
        fwd_valid = fv; fwd_data = fd; bwd_valid = bv; bwd_grad = bg; clr_flags = clr;
        if (clr) begin m_ovf = 0; m_unf = 0; end
        m_gv = bv;
        m_go = '0;
        if (bv) begin
            if (mq.size() > 0) begin
                bit m = mq.pop_front();
                m_go = m ? bg : masked_grad(bg);
            end else m_unf = 1;
        end
        if (fv) begin
            if (mq.size() < D) mq.push_back($signed(fd) > 0);
            else m_ovf = 1;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; fwd_valid = 0; bwd_valid = 0; clr_flags = 0;
        repeat (n) @(posedge clk);
        #1;
        mq.delete(); m_ovf = 0; m_unf = 0; m_gv = 0; m_go = '0;
        check_all();
        rst_n = 1;
    endtask

    initial begin
        do_reset(2);
        cycle(1, 32'h0000_0005, 0, '0, 0);
        cycle(1, 32'hFFFF_FFFB, 0, '0, 0);
        cycle(1, 32'h0000_0000, 0, '0, 0);
        repeat (3) cycle(0, '0, 1, 32'h0000_0010, 0);
        cycle(0, '0, 0, '0, 0);
        for (int i = 0; i < D; i++) cycle(1, i[0] ? 32'h8000_0000 : 32'h7FFF_FFFF, 0, '0, 0);
        cycle(1, 32'h0000_0001, 0, '0, 0);
        for (int i = 0; i < D; i++) cycle(0, '0, 1, 32'h0000_0001, 0);
        cycle(0, '0, 0, '0, 0);
        cycle(0, '0, 0, '0, 1);
        cycle(0, '0, 1, 32'h1234_5678, 0);
        cycle(0, '0, 0, '0, 1);
        cycle(0, '0, 0, '0, 0);
        cycle(1, 32'h0000_0003, 1, 32'h0000_0077, 0);
        cycle(0, '0, 1, 32'h0000_0055, 1);
        for (int i = 0; i < D; i++) cycle(1, $urandom, 0, '0, 0);
        cycle(1, 32'h0000_0009, 1, 32'h0000_0abc, 1);
        cycle(0, '0, 1, $urandom, 0);
        cycle(0, '0, 0, '0, 1);
        for (int i = 0; i < 300; i++) cycle(1, $urandom, 1, $urandom, 0);
        do_reset(1);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, $urandom_range(0, 15) == 0);
        do_reset(1);
`ifdef LEAKY_GRAD_EN
        cycle(1, 32'hFFFF_FF00, 0, '0, 0);
        cycle(0, '0, 1, 32'hFFFF_FFC0, 0);
        cycle(1, 32'h0000_0001, 0, '0, 0);
        cycle(0, '0, 1, 32'h0000_0040, 0);
        cycle(0, '0, 1, 32'hFFFF_FFC0, 0);
`endif
        cycle(0, '0, 0, '0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-direction counterpart of the ReLU activation stage: gates a stream of SUM_WIDTH gradients using activation masks recorded during the forward pass.
- During the forward pass it snoops the pre-activation sums entering the ReLU and stores one mask bit per element in a DEPTH-entry FIFO.
- During the backward pass it pops one mask per incoming gradient and outputs the gradient unchanged (mask=1) or zeroed (mask=0), in the same element order as the forward pass.

Parameters:
- SUM_WIDTH, 32, width of forward sums and gradients (two's complement).
- DEPTH, 128, mask FIFO entries (elements per layer); power of two, at least 2.
- LEAK_SHIFT, 3, right-shift applied to gradients of non-positive elements; used only when LEAKY_GRAD_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fwd_valid  in  1  fwd_data valid this cycle; pushes one mask bit
- fwd_data  in  SUM_WIDTH  pre-activation sum, signed
- bwd_valid  in  1  bwd_grad valid this cycle; pops one mask bit
- bwd_grad  in  SUM_WIDTH  upstream gradient, signed
- clr_flags  in  1  clears the overflow and underflow flags
- grad_valid  out  1  grad_out valid, registered
- grad_out  out  SUM_WIDTH  gated gradient, registered
- mask_count  out  $clog2(DEPTH+1)  number of stored masks
- full  out  1  mask_count == DEPTH
- empty  out  1  mask_count == 0
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- underflow  out  1  sticky: a pop was attempted on an empty FIFO

Behaviour:
- Reset (rst_n low at posedge clk):
  - wr_ptr, rd_ptr and mask_count go to 0.
  - grad_valid, grad_out, overflow and underflow go to 0.
  - empty=1, full=0.
  - Mask storage contents need not be reset.
  - Reset mid-operation discards all stored masks. The next cycle after reset release behaves as a fresh layer.
- Mask rule: mask = 1 iff the signed value of fwd_data is > 0. Zero and negative values give mask 0, consistent with ReLU passing only positive sums.
- Push: on fwd_valid with full=0, write the mask at wr_ptr and increment wr_ptr modulo DEPTH.
- Pop: on bwd_valid with empty=0, read the mask at rd_ptr and increment rd_ptr modulo DEPTH.
- Pointer wrap: both pointers wrap at DEPTH with no bubble.
- Latency: exactly 1 cycle.
  - grad_valid(t+1) = bwd_valid(t).
  - grad_out(t+1) = bwd_grad(t) if the popped mask = 1, else 0.
  - When grad_valid = 0, grad_out holds 0.
- Underflow: bwd_valid while empty, with no simultaneous push.
  - grad_valid still asserts next cycle with grad_out = 0.
  - underflow sets; rd_ptr and mask_count are unchanged.
- Overflow: fwd_valid while full, with no simultaneous pop.
  - The push is dropped and overflow sets; wr_ptr and mask_count are unchanged.
- Simultaneous push and pop:
  - Not full and not empty: both occur, mask_count unchanged.
  - Full: the pop frees a slot and the push is accepted. No overflow; mask_count stays DEPTH.
  - Empty: the pop is an underflow (no bypass of the incoming mask). The push is accepted and mask_count becomes 1.
- mask_count: +1 on an accepted push only, -1 on a successful pop only, unchanged otherwise.
- Sticky flags:
  - clr_flags clears overflow and underflow.
  - If clr_flags and a new error occur in the same cycle, the flag is set (set wins).
- full and empty are combinational decodes of mask_count.

Optional Feature:
- Macro: LEAKY_GRAD_EN.
- Defined: a popped mask of 0 gives grad_out = bwd_grad >>> LEAK_SHIFT (arithmetic shift), approximating the leaky-ReLU derivative. Underflow still outputs 0.
- Not defined: a popped mask of 0 gives grad_out = 0, and LEAK_SHIFT is unused.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles -> grad_valid=0, grad_out=0, mask_count=0, empty=1, full=0, overflow=0, underflow=0.
- Basic gating: push fwd_data 0x00000005, 0xFFFFFFFB, 0x00000000; then apply bwd_grad 0x00000010 three times -> grad_out 0x00000010, 0x00000000, 0x00000000 on consecutive cycles, each exactly 1 cycle after its bwd_valid; mask_count returns to 0.
- Full FIFO: push 128 values alternating 0x7FFFFFFF and 0x80000000 -> full=1, mask_count=128. A 129th push -> overflow=1, mask_count stays 128. Pop 128 grads of 0x00000001 -> alternating 0x00000001/0x00000000 with no extra element.
- Underflow and flag clear: bwd_valid on empty with bwd_grad 0x12345678 -> next cycle grad_valid=1, grad_out=0, underflow=1. Pulse clr_flags -> underflow=0.
- Concurrent traffic and wrap: with 127 masks stored, run 300 cycles of simultaneous push/pop using random signed data -> mask_count stays 127, no flags set, outputs match a reference model across pointer wrap. Assert rst_n low mid-stream -> mask_count=0 on the next cycle.
- LEAKY_GRAD_EN defined: push 0xFFFFFF00, pop with bwd_grad 0xFFFFFFC0 -> grad_out 0xFFFFFFF8. Push 0x00000001, pop with 0x00000040 -> grad_out 0x00000040.
